// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 multiplier types and constants
// FSM encodings, FP32 field constants and the unpacked-operand record.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0]  EXP_ALL1  = 8'hff;
  localparam logic [9:0]  BIAS      = 10'd127;
  localparam logic [22:0] QNAN_FRAC = 23'h400000;
  localparam logic [3:0]  ITER_LAST = 4'd11;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp10;
    logic [23:0] sig_a;
    logic [23:0] sig_b;
    logic        is_inf_nan;
    logic [22:0] inf_nan_frac;
  } unpack_t;

  // 3*x without a multiplier; 26 bits always holds the result.
  function automatic logic [25:0] times3(input logic [23:0] x);
    return {2'b00, x} + {1'b0, x, 1'b0};
  endfunction

endpackage

// File: rtl/fmul_mant_iter_if.sv
// rtl/fmul_mant_iter_if.sv - operand/result handshake bundle of the mantissa stage
// master = upstream/downstream side, slave = the iterative multiplier.
interface fmul_mant_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  rm_in;
  logic        cancel;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  rm;
  logic        sign;
  logic [9:0]  exp10;
  logic        is_inf_nan;
  logic [22:0] inf_nan_frac;
  logic [47:0] z;

  modport master (
    output in_valid, a, b, rm_in, cancel, out_ready,
    input  in_ready, out_valid, rm, sign, exp10, is_inf_nan, inf_nan_frac, z
  );

  modport slave (
    input  in_valid, a, b, rm_in, cancel, out_ready,
    output in_ready, out_valid, rm, sign, exp10, is_inf_nan, inf_nan_frac, z
  );
endinterface

// File: rtl/fmul_unpack.sv
// rtl/fmul_unpack.sv - combinational FP32 operand unpack for the multiplier
// Denormals use exponent 1 and a clear hidden bit; exp10 may wrap negative.
module fmul_unpack
  import fpu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output unpack_t     o_f
);

  logic [7:0]  w_ea_raw;
  logic [7:0]  w_eb_raw;
  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [22:0] w_fa;
  logic [22:0] w_fb;
  logic        w_a_inf_nan;
  logic        w_b_inf_nan;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_a_zero;
  logic        w_b_zero;
  logic        w_inf_x_zero;

  assign w_ea_raw = i_a[30:23];
  assign w_eb_raw = i_b[30:23];
  assign w_fa     = i_a[22:0];
  assign w_fb     = i_b[22:0];

  assign w_ea = (w_ea_raw == 8'd0) ? 8'd1 : w_ea_raw;
  assign w_eb = (w_eb_raw == 8'd0) ? 8'd1 : w_eb_raw;

  assign w_a_inf_nan = (w_ea_raw == EXP_ALL1);
  assign w_b_inf_nan = (w_eb_raw == EXP_ALL1);
  assign w_a_nan     = w_a_inf_nan & (w_fa != 23'd0);
  assign w_b_nan     = w_b_inf_nan & (w_fb != 23'd0);
  assign w_a_zero    = (w_ea_raw == 8'd0) & (w_fa == 23'd0);
  assign w_b_zero    = (w_eb_raw == 8'd0) & (w_fb == 23'd0);

  // inf x 0 has no meaningful magnitude, so it is reported as a quiet NaN.
  assign w_inf_x_zero = (w_a_inf_nan & w_b_zero) | (w_b_inf_nan & w_a_zero);

  always_comb begin
    o_f              = '0;
    o_f.sign         = i_a[31] ^ i_b[31];
    o_f.exp10        = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;
    o_f.sig_a        = {w_ea_raw != 8'd0, w_fa};
    o_f.sig_b        = {w_eb_raw != 8'd0, w_fb};
    o_f.is_inf_nan   = w_a_inf_nan | w_b_inf_nan;
    o_f.inf_nan_frac = (w_a_nan | w_b_nan | w_inf_x_zero) ? QNAN_FRAC : 23'd0;
  end

endmodule

// File: rtl/fmul_mant_iter.sv
// rtl/fmul_mant_iter.sv - iterative radix-4 FP32 significand multiply stage
// Accepts operands in IDLE, runs 12 shift-add steps in MUL, presents the result in DONE.
module fmul_mant_iter
  import fpu_pkg::*;
(
  input  logic            clk,
  input  logic            clrn,
  fmul_mant_iter_if.slave bus
);

  state_t      r_state;
  state_t      w_next;
  unpack_t     w_unp;
  logic        w_accept;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_last_iter;

  logic [1:0]  r_rm;
  logic        r_sign;
  logic [9:0]  r_exp10;
  logic        r_is_inf_nan;
  logic [22:0] r_inf_nan_frac;
  logic [47:0] r_z;

  logic [23:0] r_a;
  logic [25:0] r_a3;
  logic [25:0] r_acc;
  logic [23:0] r_bsr;
  logic [3:0]  r_count;
  logic [25:0] w_da;
  logic [25:0] w_sum;

  fmul_unpack u_unpack (
    .i_a (bus.a),
    .i_b (bus.b),
    .o_f (w_unp)
  );

  assign w_accept    = bus.in_valid & (r_state == ST_IDLE) & ~bus.cancel;
  assign w_last_iter = (r_count == ITER_LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // cancel outranks every other transition, including a same-cycle accept or handshake.
  always_comb begin
    w_next = r_state;
    if (bus.cancel) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            w_next = w_unp.is_inf_nan ? ST_DONE : ST_MUL;
          end
        end
        ST_MUL: begin
          if (w_last_iter) begin
            w_next = ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            w_next = ST_IDLE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: w_in_ready  = 1'b1;
      ST_DONE: w_out_valid = 1'b1;
      default: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
      end
    endcase
  end

  // Radix-4 digit select: the two low multiplier bits pick 0, A, 2A or 3A.
  always_comb begin
    w_da = '0;
    unique case (r_bsr[1:0])
      2'd0: w_da = '0;
      2'd1: w_da = {2'b00, r_a};
      2'd2: w_da = {1'b0, r_a, 1'b0};
      2'd3: w_da = r_a3;
      default: w_da = '0;
    endcase
  end

  // acc stays below A, so acc + 3A never overflows 26 bits.
  assign w_sum = r_acc + w_da;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_rm           <= '0;
      r_sign         <= 1'b0;
      r_exp10        <= '0;
      r_is_inf_nan   <= 1'b0;
      r_inf_nan_frac <= '0;
      r_z            <= '0;
      r_a            <= '0;
      r_a3           <= '0;
      r_acc          <= '0;
      r_bsr          <= '0;
      r_count        <= '0;
    end else if (w_accept) begin
      r_rm           <= bus.rm_in;
      r_sign         <= w_unp.sign;
      r_exp10        <= w_unp.exp10;
      r_is_inf_nan   <= w_unp.is_inf_nan;
      r_inf_nan_frac <= w_unp.inf_nan_frac;
      r_z            <= '0;
      r_a            <= w_unp.sig_a;
      r_a3           <= times3(w_unp.sig_a);
      r_acc          <= '0;
      r_bsr          <= w_unp.sig_b;
      r_count        <= '0;
    end else if (bus.cancel) begin
      r_acc          <= '0;
      r_count        <= '0;
    end else if (r_state == ST_MUL) begin
      r_acc          <= {2'b00, w_sum[25:2]};
      r_bsr          <= {w_sum[1:0], r_bsr[23:2]};
      r_count        <= r_count + 4'd1;
      if (w_last_iter) begin
        r_z <= {w_sum, r_bsr[23:2]};
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.rm           = r_rm;
  assign bus.sign         = r_sign;
  assign bus.exp10        = r_exp10;
  assign bus.is_inf_nan   = r_is_inf_nan;
  assign bus.inf_nan_frac = r_inf_nan_frac;
  assign bus.z            = r_z;

endmodule
